// File: rtl/sctag_mbcam_ctl.sv
// Miss-buffer address CAM controller: owns entry valid state, allocates free entries,
// drives CAM writes/lookups and turns the raw match vector into a qualified hit response.
module sctag_mbcam_ctl (
   input  logic        rclk,
   input  logic        rst_l,
   input  logic        alloc_req,
   input  logic [39:0] alloc_addr,
   output logic        alloc_gnt,
   output logic [3:0]  alloc_idx,
   input  logic        dealloc_vld,
   input  logic [3:0]  dealloc_idx,
   input  logic        lkup_req,
   input  logic [31:0] lkup_key,
   output logic        lkup_rsp_vld,
   output logic        lkup_hit,
   output logic [3:0]  lkup_hit_idx,
   output logic        lkup_multi_hit,
   output logic [15:0] cam_adr_w,
   output logic [39:0] cam_din,
   output logic        cam_write_en,
   output logic        cam_lookup_en,
   output logic [31:0] cam_key,
   input  logic [15:0] cam_match,
   output logic [4:0]  count,
   output logic        full,
   output logic        empty
);

   function automatic logic [3:0] lsb_idx(input logic [15:0] vec);
      logic [3:0] idx_v;
      idx_v = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) idx_v = i[3:0];
      end
      return idx_v;
   endfunction

   function automatic logic more_than_one(input logic [15:0] vec);
      return (vec & (vec - 16'd1)) != 16'd0;
   endfunction

   logic [15:0] vld_r;
   logic [4:0]  count_r;
   logic        p1_vld_r;
   logic [15:0] p1_mask_r;
   logic        rsp_vld_r;
   logic        hit_r;
   logic [3:0]  hit_idx_r;
   logic        multi_r;

   logic [3:0]  free_idx_s;
   logic        gnt_s;
   logic [15:0] gnt_oh_s;
   logic        dealloc_eff_s;
   logic [15:0] dealloc_oh_s;
   logic [15:0] q_s;
   logic        full_s;

   assign full_s = (count_r == 5'd16);

   // Allocation pick, effective dealloc and qualified match; CAM drives read 0 in reset.
   always_comb begin
      free_idx_s    = lsb_idx(~vld_r);
      gnt_s         = rst_l & alloc_req & ~full_s;
      dealloc_eff_s = dealloc_vld & vld_r[dealloc_idx];
      q_s           = cam_match & p1_mask_r;
      gnt_oh_s      = 16'd0;
      dealloc_oh_s  = 16'd0;
      if (gnt_s) begin
         gnt_oh_s = 16'd1 << free_idx_s;
      end else begin
         gnt_oh_s = 16'd0;
      end
      if (dealloc_eff_s) begin
         dealloc_oh_s = 16'd1 << dealloc_idx;
      end else begin
         dealloc_oh_s = 16'd0;
      end
   end

   assign alloc_gnt     = gnt_s;
   assign alloc_idx     = rst_l ? free_idx_s : 4'd0;
   assign cam_write_en  = gnt_s;
   assign cam_adr_w     = gnt_oh_s;
   assign cam_din       = rst_l ? alloc_addr : 40'd0;
   assign cam_lookup_en = rst_l & lkup_req;
   assign cam_key       = rst_l ? lkup_key : 32'd0;

   // Entry valid vector and occupancy count.
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         vld_r   <= 16'd0;
         count_r <= 5'd0;
      end else begin
         vld_r   <= (vld_r | gnt_oh_s) & ~dealloc_oh_s;
         count_r <= count_r + {4'd0, gnt_s} - {4'd0, dealloc_eff_s};
      end
   end

   // Lookup pipe: the mask excludes entries freed now and entries still being written.
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         p1_vld_r  <= 1'b0;
         p1_mask_r <= 16'd0;
         rsp_vld_r <= 1'b0;
         hit_r     <= 1'b0;
         hit_idx_r <= 4'd0;
         multi_r   <= 1'b0;
      end else begin
         p1_vld_r  <= lkup_req;
         p1_mask_r <= vld_r & ~dealloc_oh_s;
         rsp_vld_r <= p1_vld_r;
         hit_r     <= |q_s;
         hit_idx_r <= lsb_idx(q_s);
         multi_r   <= more_than_one(q_s);
      end
   end

   assign lkup_rsp_vld   = rsp_vld_r;
   assign lkup_hit       = hit_r;
   assign lkup_hit_idx   = hit_idx_r;
   assign lkup_multi_hit = multi_r;
   assign count          = count_r;
   assign full           = full_s;
   assign empty          = (count_r == 5'd0);

endmodule

// File: tb/tb_sctag_mbcam_ctl.sv
// Scoreboard bench for sctag_mbcam_ctl with a behavioural CAM and an entry-list reference model.
module tb_sctag_mbcam_ctl;

   logic        rclk = 1'b0;
   logic        rst_l;
   logic        alloc_req, dealloc_vld, lkup_req;
   logic [39:0] alloc_addr;
   logic [3:0]  dealloc_idx;
   logic [31:0] lkup_key;
   logic        alloc_gnt, lkup_rsp_vld, lkup_hit, lkup_multi_hit;
   logic [3:0]  alloc_idx, lkup_hit_idx;
   logic [15:0] cam_adr_w, cam_match;
   logic [39:0] cam_din;
   logic        cam_write_en, cam_lookup_en, full, empty;
   logic [31:0] cam_key;
   logic [4:0]  count;

   sctag_mbcam_ctl dut (
      .rclk(rclk), .rst_l(rst_l),
      .alloc_req(alloc_req), .alloc_addr(alloc_addr), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
      .dealloc_vld(dealloc_vld), .dealloc_idx(dealloc_idx),
      .lkup_req(lkup_req), .lkup_key(lkup_key),
      .lkup_rsp_vld(lkup_rsp_vld), .lkup_hit(lkup_hit), .lkup_hit_idx(lkup_hit_idx),
      .lkup_multi_hit(lkup_multi_hit),
      .cam_adr_w(cam_adr_w), .cam_din(cam_din), .cam_write_en(cam_write_en),
      .cam_lookup_en(cam_lookup_en), .cam_key(cam_key), .cam_match(cam_match),
      .count(count), .full(full), .empty(empty)
   );

   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge rclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural CAM: a lookup returns its match vector one cycle later; an entry
   // being written in the lookup cycle is reported as matching (stands in for X).
   logic [31:0] cam_store [16];
   logic [15:0] cam_wr = 16'd0;
   always @(posedge rclk) begin
      logic [15:0] mv;
      for (int i = 0; i < 16; i++)
         mv[i] = (cam_wr[i] && cam_store[i] == cam_key) || (cam_write_en && cam_adr_w[i]);
      if (cam_lookup_en) cam_match <= mv;
      else               cam_match <= 16'($urandom);
      if (cam_write_en)
         for (int i = 0; i < 16; i++)
            if (cam_adr_w[i]) begin
               cam_store[i] <= cam_din[39:8];
               cam_wr[i]    <= 1'b1;
            end
   end

   // Reference model: which entries hold a live key, and how many.
   bit   [15:0] m_vld;
   logic [31:0] m_key [16];
   int          m_cnt;

   typedef struct {
      int       cyc;
      bit       hit;
      bit [3:0] idx;
      bit       multi;
   } exp_t;
   exp_t sb[$];

   // Monitor: compare the response due this cycle, flag any unexpected one.
   always @(negedge rclk) begin
      if (rst_l) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_vld", lkup_rsp_vld, 1);
            chk("hit", lkup_hit, e.hit);
            chk("hit_idx", lkup_hit_idx, e.idx);
            chk("multi_hit", lkup_multi_hit, e.multi);
         end else begin
            chk("rsp_spurious", lkup_rsp_vld, 0);
         end
      end
   end

   task automatic step(input bit a, input logic [39:0] addr, input bit d, input logic [3:0] di,
                       input bit l, input logic [31:0] k);
      int fi;
      int nh;
      bit gnt;
      logic [15:0] oh;
      exp_t e;
      alloc_req = a; alloc_addr = addr; dealloc_vld = d; dealloc_idx = di;
      lkup_req = l; lkup_key = k;
      @(negedge rclk);
      fi = 0;
      for (int i = 15; i >= 0; i--) if (!m_vld[i]) fi = i;
      gnt = a && (m_cnt < 16);
      chk("alloc_gnt", alloc_gnt, gnt);
      chk("cam_write_en", cam_write_en, gnt);
      if (gnt) begin
         oh = 16'd1 << fi;
         chk("alloc_idx", alloc_idx, fi);
         chk("cam_adr_w", cam_adr_w, oh);
         chk("cam_din", cam_din, addr);
      end else begin
         chk("cam_adr_w_idle", cam_adr_w, 0);
      end
      chk("count", count, m_cnt);
      chk("full", full, m_cnt == 16);
      chk("empty", empty, m_cnt == 0);
      chk("cam_lookup_en", cam_lookup_en, l);
      if (l) begin
         chk("cam_key", cam_key, k);
         nh = 0;
         e.idx = 4'd0;
         for (int i = 0; i < 16; i++)
            if (m_vld[i] && !(d && di == i) && m_key[i] == k) begin
               if (nh == 0) e.idx = i;
               nh++;
            end
         e.cyc = cyc + 2;
         e.hit = nh > 0;
         e.multi = nh > 1;
         sb.push_back(e);
      end
      @(posedge rclk);
      if (d && m_vld[di]) begin
         m_vld[di] = 1'b0;
         m_cnt--;
      end
      if (gnt) begin
         m_vld[fi] = 1'b1;
         m_key[fi] = addr[39:8];
         m_cnt++;
      end
      #1;
   endtask

   task automatic idle();
      step(0, 40'd0, 0, 4'd0, 0, 32'd0);
   endtask

   task automatic do_reset();
      rst_l = 1'b0;
      alloc_req = 1'b1; alloc_addr = 40'hFF_FFFF_FFFF; dealloc_vld = 1'b0;
      dealloc_idx = 4'd0; lkup_req = 1'b1; lkup_key = 32'hFFFF_FFFF;
      sb.delete();
      m_vld = 16'd0;
      m_cnt = 0;
      #2;
      chk("rst_alloc_gnt", alloc_gnt, 0);
      chk("rst_cam_write_en", cam_write_en, 0);
      chk("rst_cam_adr_w", cam_adr_w, 0);
      chk("rst_cam_din", cam_din, 0);
      chk("rst_cam_lookup_en", cam_lookup_en, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rsp", {lkup_rsp_vld, lkup_hit, lkup_hit_idx, lkup_multi_hit}, 0);
      @(posedge rclk);
      #1;
      alloc_req = 1'b0;
      lkup_req = 1'b0;
      rst_l = 1'b1;
   endtask

   logic [31:0] pool [4];

   initial begin
      rst_l = 1'b1;
      pool[0] = 32'hA000_0000; pool[1] = 32'hA000_0001;
      pool[2] = 32'h5A5A_0F0F; pool[3] = 32'h1234_5678;
      #1;
      do_reset();

      // Fill all 16 entries, then one request past full.
      for (int i = 0; i < 16; i++) step(1, {32'hC000_0000 + 32'(i), 8'(i)}, 0, 4'd0, 0, 32'd0);
      step(1, 40'h11_1111_1111, 0, 4'd0, 0, 32'd0);
      idle();

      // Alloc-then-lookup visibility, and a same-cycle lookup that must miss.
      do_reset();
      step(1, 40'h12_3456_7800, 0, 4'd0, 1, 32'h1234_5678);
      step(0, 40'd0, 0, 4'd0, 1, 32'h1234_5678);
      idle(); idle();

      // Same-cycle alloc and dealloc: freed entry only reusable a cycle later.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, {32'hD000_0000 + 32'(i), 8'd0}, 0, 4'd0, 0, 32'd0);
      step(1, 40'hD0_0000_0400, 1, 4'd2, 0, 32'd0);
      step(1, 40'hD0_0000_0500, 0, 4'd0, 0, 32'd0);
      chk("reuse_idx2", m_key[2], 32'hD000_0005);

      // Duplicate keys in entries 3 and 9, then the same lookup while 3 is freed.
      do_reset();
      for (int i = 0; i < 10; i++)
         step(1, {((i == 3 || i == 9) ? 32'hBEEF_0001 : 32'hB000_0000 + 32'(i)), 8'h00},
              0, 4'd0, 0, 32'd0);
      step(0, 40'd0, 0, 4'd0, 1, 32'hBEEF_0001);
      step(0, 40'd0, 1, 4'd3, 1, 32'hBEEF_0001);
      step(0, 40'd0, 1, 4'd15, 0, 32'd0);
      idle(); idle();

      // Reset one cycle after a lookup: its response must never appear.
      step(0, 40'd0, 0, 4'd0, 1, 32'hB000_0000);
      do_reset();
      idle(); idle(); idle();

      // Randomized traffic over a small key pool so hits and multi-hits are frequent.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 127) == 0) do_reset();
         step($urandom_range(0, 2) != 0, {pool[$urandom_range(0, 3)], 8'($urandom)},
              $urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 1) == 1,
              pool[$urandom_range(0, 3)]);
      end
      idle(); idle(); idle();
      chk("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
